stream_burst_sched: RTL and testbench

Burst-granularity scheduler sitting between the two slave pixel streams (slv0, slv1) and the shared output FIFO of the image-processing accelerator. It grants the FIFO write path to one stream for up to BURST_LEN beats, alternates fairly when both streams request, and throttles on FIFO credit rather than a late full flag. It aborts cleanly on master frame completion. The downstream merged stream (slvx_*) is fully registered.

---
 rtl/stream_burst_sched.sv | 116 +++++++++++
 tb/tb_stream_burst_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_burst_sched.sv
// rtl/stream_burst_sched.sv - burst-granularity round-robin scheduler merging two pixel streams into a credit-limited FIFO
module stream_burst_sched #(
  parameter int DW         = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    slv0_mode,
  input  logic [1:0]    slv1_mode,
  input  logic          slv0_data_valid,
  input  logic          slv1_data_valid,
  input  logic          slv0_proc_valid,
  input  logic          slv1_proc_valid,
  input  logic [DW-1:0] slv0_data,
  input  logic [DW-1:0] slv1_data,
  output logic          slv0_ready,
  output logic          slv1_ready,
  input  logic [LW-1:0] fifo_level,
  input  logic          mstr0_cmplt,
  output logic          slvx_data_valid,
  output logic [DW-1:0] slvx_data,
  output logic [1:0]    slvx_mode,
  output logic          slvx_proc_val,
  output logic          data_source
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [LW:0]   DEPTH_L  = (LW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t        state;
  logic          rr;
  logic [CW-1:0] beat_cnt;

  logic [1:0]    g_mode;
  logic          g_valid;
  logic          g_proc;
  logic [DW-1:0] g_data;
  logic [LW:0]   occupancy;
  logic          space_ok;
  logic          grant_ok;
  logic          accepted;
  logic          burst_end;
  logic          elig0;
  logic          elig1;

  assign g_mode  = data_source ? slv1_mode       : slv0_mode;
  assign g_valid = data_source ? slv1_data_valid : slv0_data_valid;
  assign g_proc  = data_source ? slv1_proc_valid : slv0_proc_valid;
  assign g_data  = data_source ? slv1_data       : slv0_data;

  // The beat sitting in the output register is about to land in the FIFO but is not yet in fifo_level.
  assign occupancy = {1'b0, fifo_level} + {{LW{1'b0}}, slvx_data_valid};
  assign space_ok  = occupancy < DEPTH_L;

  assign grant_ok   = (state == BURST) & space_ok & ~mstr0_cmplt;
  assign slv0_ready = grant_ok & ~data_source;
  assign slv1_ready = grant_ok & data_source;
  assign accepted   = grant_ok & g_valid;
  assign burst_end  = (accepted & (beat_cnt == LAST_CNT)) | (g_mode == 2'd0);

  assign elig0 = slv0_mode != 2'd0;
  assign elig1 = slv1_mode != 2'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      data_source     <= 1'b0;
      rr              <= 1'b0;
      beat_cnt        <= '0;
      slvx_data_valid <= 1'b0;
      slvx_data       <= '0;
      slvx_mode       <= 2'd0;
      slvx_proc_val   <= 1'b0;
    end else if (mstr0_cmplt) begin
      state           <= DONE;
      data_source     <= 1'b0;
      rr              <= 1'b0;
      beat_cnt        <= '0;
      slvx_data_valid <= 1'b0;
      slvx_data       <= '0;
      slvx_mode       <= 2'd0;
      slvx_proc_val   <= 1'b0;
    end else begin
      slvx_data_valid <= accepted;
      slvx_data       <= accepted ? g_data : '0;
      slvx_proc_val   <= accepted & g_proc;
      if (accepted) slvx_mode <= g_mode;

      case (state)
        IDLE: begin
          if (elig0 | elig1) begin
            data_source <= (elig0 & elig1) ? rr : elig1;
            beat_cnt    <= '0;
            state       <= BURST;
          end
        end
        BURST: begin
          if (burst_end) begin
            state <= IDLE;
            rr    <= ~data_source;
          end else if (accepted) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_burst_sched.sv
// tb/tb_stream_burst_sched.sv - scoreboard bench for stream_burst_sched
module tb_stream_burst_sched;

  localparam int DW         = 32;
  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 64;
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    slv0_mode, slv1_mode;
  logic          slv0_data_valid, slv1_data_valid;
  logic          slv0_proc_valid, slv1_proc_valid;
  logic [DW-1:0] slv0_data, slv1_data;
  logic          slv0_ready, slv1_ready;
  logic [LW-1:0] fifo_level;
  logic          mstr0_cmplt;
  logic          slvx_data_valid;
  logic [DW-1:0] slvx_data;
  logic [1:0]    slvx_mode;
  logic          slvx_proc_val;
  logic          data_source;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          proc;
    logic [1:0]    mode;
    logic          src;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  stream_burst_sched #(
    .DW(DW), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .LW(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .slv0_mode(slv0_mode), .slv1_mode(slv1_mode),
    .slv0_data_valid(slv0_data_valid), .slv1_data_valid(slv1_data_valid),
    .slv0_proc_valid(slv0_proc_valid), .slv1_proc_valid(slv1_proc_valid),
    .slv0_data(slv0_data), .slv1_data(slv1_data),
    .slv0_ready(slv0_ready), .slv1_ready(slv1_ready),
    .fifo_level(fifo_level), .mstr0_cmplt(mstr0_cmplt),
    .slvx_data_valid(slvx_data_valid), .slvx_data(slvx_data),
    .slvx_mode(slvx_mode), .slvx_proc_val(slvx_proc_val),
    .data_source(data_source)
  );

  always #5 clk = ~clk;

  // One scoreboard step per clock: retire last cycle's expected beat, enqueue this cycle's handshakes, then advance.
  task automatic tick();
    beat_t got, exp_b;
    if (!rst) begin
      if (slvx_data_valid) begin
        n_checks++;
        got = {slvx_data, slvx_proc_val, slvx_mode, data_source};
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra_write: got data=%h, expected no write", slvx_data);
        end else begin
          exp_b = sb.pop_front();
          if (got !== exp_b) begin
            n_fail++;
            $display("FAIL sb_beat: got data=%h proc=%b mode=%0d src=%b, expected data=%h proc=%b mode=%0d src=%b",
                     got.data, got.proc, got.mode, got.src, exp_b.data, exp_b.proc, exp_b.mode, exp_b.src);
          end
        end
      end else if (sb.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_missing_write: got no write, expected data=%h", sb[0].data);
        sb.delete();
      end
      if (slv0_ready && slv0_data_valid) sb.push_back({slv0_data, slv0_proc_valid, slv0_mode, 1'b0});
      if (slv1_ready && slv1_data_valid) sb.push_back({slv1_data, slv1_proc_valid, slv1_mode, 1'b1});
    end else begin
      sb.delete();
    end
    @(posedge clk);
    #1;
    slv0_data       = $urandom();
    slv1_data       = $urandom();
    slv0_proc_valid = 1'($urandom_range(0, 1));
    slv1_proc_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_streams(input int cycles);
    slv0_mode = 2'd0; slv1_mode = 2'd0;
    slv0_data_valid = 1'b0; slv1_data_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (slvx_data_valid !== 1'b0 || slvx_proc_val !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got dv=%b pv=%b, expected 0 0", slvx_data_valid, slvx_proc_val);
    end
    n_checks++;
    if (slvx_data !== '0 || slvx_mode !== 2'd0) begin
      n_fail++; $display("FAIL reset_data: got data=%h mode=%0d, expected 0 0", slvx_data, slvx_mode);
    end
    n_checks++;
    if (data_source !== 1'b0) begin
      n_fail++; $display("FAIL reset_source: got %b, expected 0", data_source);
    end
    n_checks++;
    if (slv0_ready !== 1'b0 || slv1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got r0=%b r1=%b, expected 0 0", slv0_ready, slv1_ready);
    end
    rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (slv0_ready !== 1'b0 || slv1_ready !== 1'b0 || slvx_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_quiet: got r0=%b r1=%b dv=%b, expected 0 0 0", slv0_ready, slv1_ready, slvx_data_valid);
    end
    tick();
  endtask

  task automatic test_fairness();
    int a0, a1, phase, src;
    logic e0, e1;
    a0 = 0; a1 = 0;
    slv0_mode = 2'd2; slv1_mode = 2'd2;
    slv0_data_valid = 1'b1; slv1_data_valid = 1'b1;
    for (int k = 0; k < 4 * (BURST_LEN + 1); k++) begin
      @(negedge clk);
      phase = k % (BURST_LEN + 1);
      src   = (k / (BURST_LEN + 1)) % 2;
      e0 = (phase != 0) && (src == 0);
      e1 = (phase != 0) && (src == 1);
      n_checks++;
      if (slv0_ready !== e0 || slv1_ready !== e1) begin
        n_fail++; $display("FAIL fair_ready k=%0d: got r0=%b r1=%b, expected r0=%b r1=%b", k, slv0_ready, slv1_ready, e0, e1);
      end
      if (phase != 0) begin
        n_checks++;
        if (data_source !== 1'(src)) begin
          n_fail++; $display("FAIL fair_source k=%0d: got %b, expected %0d", k, data_source, src);
        end
      end
      if (slv0_ready && slv0_data_valid) a0++;
      if (slv1_ready && slv1_data_valid) a1++;
      tick();
    end
    n_checks++;
    if (a0 != 2 * BURST_LEN || a1 != 2 * BURST_LEN || (a0 - a1 > BURST_LEN) || (a1 - a0 > BURST_LEN)) begin
      n_fail++; $display("FAIL fair_counts: got beats0=%0d beats1=%0d, expected %0d each", a0, a1, 2 * BURST_LEN);
    end
    idle_streams(3);
  endtask

  task automatic test_single_stream();
    int a0;
    logic e0;
    a0 = 0;
    slv0_mode = 2'd1; slv0_data_valid = 1'b1;
    for (int k = 0; k < 2 * (BURST_LEN + 1); k++) begin
      @(negedge clk);
      e0 = (k % (BURST_LEN + 1)) != 0;
      n_checks++;
      if (slv0_ready !== e0 || slv1_ready !== 1'b0) begin
        n_fail++; $display("FAIL single_ready k=%0d: got r0=%b r1=%b, expected r0=%b r1=0", k, slv0_ready, slv1_ready, e0);
      end
      if (k > 0) begin
        n_checks++;
        if (data_source !== 1'b0) begin
          n_fail++; $display("FAIL single_source k=%0d: got %b, expected 0", k, data_source);
        end
      end
      if (slv0_ready && slv0_data_valid) a0++;
      tick();
    end
    n_checks++;
    if (a0 != 2 * BURST_LEN) begin
      n_fail++; $display("FAIL single_count: got %0d beats, expected %0d", a0, 2 * BURST_LEN);
    end
    idle_streams(3);
  endtask

  task automatic test_credit();
    int acc, wr;
    acc = 0;
    fifo_level = LW'(FIFO_DEPTH - 1);
    slv0_mode = 2'd1; slv0_data_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wr = int'(slvx_data_valid);
      n_checks++;
      if (wr != 0 && int'(fifo_level) >= FIFO_DEPTH) begin
        n_fail++; $display("FAIL credit_overflow k=%0d: got write at level %0d, expected none", k, fifo_level);
      end
      if (k == 2) begin
        n_checks++;
        if (slv0_ready !== 1'b0 || slvx_data_valid !== 1'b1) begin
          n_fail++; $display("FAIL credit_stall: got r0=%b dv=%b, expected r0=0 dv=1", slv0_ready, slvx_data_valid);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (slv0_ready !== 1'b0 || slvx_data_valid !== 1'b0) begin
          n_fail++; $display("FAIL credit_full: got r0=%b dv=%b, expected 0 0", slv0_ready, slvx_data_valid);
        end
      end
      if (slv0_ready && slv0_data_valid) acc++;
      tick();
      fifo_level = fifo_level + LW'(wr);
    end
    n_checks++;
    if (acc != 1) begin
      n_fail++; $display("FAIL credit_one_beat: got %0d beats, expected 1", acc);
    end
    acc = 0;
    fifo_level = LW'(FIFO_DEPTH - 4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      wr = int'(slvx_data_valid);
      n_checks++;
      if (wr != 0 && int'(fifo_level) >= FIFO_DEPTH) begin
        n_fail++; $display("FAIL credit_overflow2 k=%0d: got write at level %0d, expected none", k, fifo_level);
      end
      if (slv0_ready && slv0_data_valid) acc++;
      tick();
      fifo_level = fifo_level + LW'(wr);
    end
    n_checks++;
    if (acc != 4) begin
      n_fail++; $display("FAIL credit_release: got %0d beats, expected 4", acc);
    end
    fifo_level = '0;
    idle_streams(3);
  endtask

  task automatic test_early_release();
    int a0;
    logic e0, e1, es;
    a0 = 0;
    slv0_mode = 2'd1; slv1_mode = 2'd3;
    slv0_data_valid = 1'b1; slv1_data_valid = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      e1 = (k >= 1) && (k <= 6);
      e0 = (k >= 8) && (k <= 7 + BURST_LEN);
      es = (k < 8);
      n_checks++;
      if (slv0_ready !== e0 || slv1_ready !== e1) begin
        n_fail++; $display("FAIL early_ready k=%0d: got r0=%b r1=%b, expected r0=%b r1=%b", k, slv0_ready, slv1_ready, e0, e1);
      end
      if (k > 0) begin
        n_checks++;
        if (data_source !== es) begin
          n_fail++; $display("FAIL early_source k=%0d: got %b, expected %b", k, data_source, es);
        end
      end
      if (slv0_ready && slv0_data_valid) a0++;
      tick();
      if (k == 5) begin
        slv1_mode = 2'd0; slv1_data_valid = 1'b0;
      end
    end
    n_checks++;
    if (a0 != BURST_LEN) begin
      n_fail++; $display("FAIL early_restart: got %0d slv0 beats, expected %0d", a0, BURST_LEN);
    end
    idle_streams(3);
  endtask

  task automatic test_abort();
    logic e0, e1;
    slv0_mode = 2'd2; slv1_mode = 2'd1;
    slv0_data_valid = 1'b1; slv1_data_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      e1 = (k >= 1) && (k <= 3);
      e0 = (k == 10);
      n_checks++;
      if (slv0_ready !== e0 || slv1_ready !== e1) begin
        n_fail++; $display("FAIL abort_ready k=%0d: got r0=%b r1=%b, expected r0=%b r1=%b", k, slv0_ready, slv1_ready, e0, e1);
      end
      if (k == 5) begin
        n_checks++;
        if (slvx_data_valid !== 1'b0 || slvx_data !== '0 || slvx_mode !== 2'd0 ||
            slvx_proc_val !== 1'b0 || data_source !== 1'b0) begin
          n_fail++; $display("FAIL abort_clear: got dv=%b data=%h mode=%0d pv=%b src=%b, expected all 0",
                             slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, data_source);
        end
      end
      if (k >= 6 && k <= 9) begin
        n_checks++;
        if (slvx_data_valid !== 1'b0) begin
          n_fail++; $display("FAIL abort_hold k=%0d: got dv=%b, expected 0", k, slvx_data_valid);
        end
      end
      if (k == 10) begin
        n_checks++;
        if (data_source !== 1'b0) begin
          n_fail++; $display("FAIL abort_regrant: got %b, expected 0", data_source);
        end
      end
      tick();
      if (k == 3) mstr0_cmplt = 1'b1;
      if (k == 7) mstr0_cmplt = 1'b0;
    end
    idle_streams(3);
  endtask

  task automatic test_reset_mid_burst();
    int a0;
    logic e0, e1;
    a0 = 0;
    slv0_mode = 2'd1; slv1_mode = 2'd2;
    slv0_data_valid = 1'b1; slv1_data_valid = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      e1 = (k >= 1) && (k <= 6);
      e0 = (k >= 9) && (k <= 8 + BURST_LEN);
      if (k != 7) begin
        n_checks++;
        if (slv0_ready !== e0 || slv1_ready !== e1) begin
          n_fail++; $display("FAIL rstmid_ready k=%0d: got r0=%b r1=%b, expected r0=%b r1=%b", k, slv0_ready, slv1_ready, e0, e1);
        end
      end
      if (k == 8) begin
        n_checks++;
        if (slvx_data_valid !== 1'b0 || slvx_data !== '0 || slvx_mode !== 2'd0 ||
            slvx_proc_val !== 1'b0 || data_source !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_clear: got dv=%b data=%h mode=%0d pv=%b src=%b, expected all 0",
                             slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, data_source);
        end
      end
      if (k >= 9 && k <= 8 + BURST_LEN) begin
        n_checks++;
        if (data_source !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_source k=%0d: got %b, expected 0", k, data_source);
        end
        if (slv0_ready && slv0_data_valid) a0++;
      end
      tick();
      if (k == 6) rst = 1'b1;
      if (k == 7) rst = 1'b0;
    end
    n_checks++;
    if (a0 != BURST_LEN) begin
      n_fail++; $display("FAIL rstmid_burst: got %0d beats, expected %0d", a0, BURST_LEN);
    end
    idle_streams(3);
  endtask

  initial begin
    rst = 1'b1;
    slv0_mode = 2'd0; slv1_mode = 2'd0;
    slv0_data_valid = 1'b0; slv1_data_valid = 1'b0;
    slv0_proc_valid = 1'b0; slv1_proc_valid = 1'b0;
    slv0_data = '0; slv1_data = '0;
    fifo_level = '0;
    mstr0_cmplt = 1'b0;

    test_reset();
    test_fairness();
    test_single_stream();
    test_credit();
    test_early_release();
    test_abort();
    test_reset_mid_burst();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending beats, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "time limit");
  end

endmodule
